// File: rtl/ika2151_seq_pkg.sv
// Shared types and default timing for the IKA2151 register-write sequencer.
package ika2151_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_PULSE,
    ST_A_HOLD,
    ST_D_SETUP,
    ST_D_PULSE,
    ST_D_HOLD,
    ST_BUSY
  } seq_state_t;

  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] d;
  } bus_drive_t;

  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_SETUP_CYC  = 15;
  localparam int unsigned DEF_PULSE_CYC  = 20;
  localparam int unsigned DEF_HOLD_CYC   = 15;
  localparam int unsigned DEF_BUSY_PHIM  = 64;

  localparam bus_drive_t BUS_RESET = '{cs_n: 1'b1, wr_n: 1'b1, a0: 1'b0, d: 8'h00};

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ika2151_wrfifo.sv
// Synchronous request FIFO holding {addr, data} pairs; push is ignored when full.
module ika2151_wrfifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [15:0]            wdata,
  output logic [15:0]            rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ika2151_write_sequencer.sv
// Replays queued (addr, data) writes onto the IKA2151 CPU bus as an address phase,
// a data phase and a busy hold-off counted in phiM enables.
module ika2151_write_sequencer
  import ika2151_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC  = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
  parameter int unsigned BUSY_PHIM  = DEF_BUSY_PHIM
) (
  input  logic                        i_EMUCLK,
  input  logic                        i_RST,
  input  logic                        i_phiM_PCEN_n,
  input  logic                        i_REQ_VALID,
  output logic                        o_REQ_READY,
  input  logic [7:0]                  i_REQ_ADDR,
  input  logic [7:0]                  i_REQ_DATA,
  output logic                        o_CS_n,
  output logic                        o_WR_n,
  output logic                        o_RD_n,
  output logic                        o_A0,
  output logic [7:0]                  o_D,
  output logic                        o_BUSY,
  output logic [$clog2(FIFO_DEPTH):0] o_LEVEL
);
  localparam int unsigned CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC)) + 1;
  localparam int unsigned BW = $clog2(BUSY_PHIM) + 1;

  seq_state_t    state;
  seq_state_t    state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_load;
  logic [BW-1:0] bcnt;
  logic          pop;
  logic          full;
  logic          empty;
  logic [15:0]   head;
  logic [15:0]   wr_q;
  bus_drive_t    drive;
  bus_drive_t    bus_q;
  logic          phim_en;
  logic          timer_done;
  logic          busy_done;

  ika2151_wrfifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_EMUCLK),
    .rst   (i_RST),
    .push  (i_REQ_VALID),
    .pop   (pop),
    .wdata ({i_REQ_ADDR, i_REQ_DATA}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (o_LEVEL)
  );

  assign phim_en    = !i_phiM_PCEN_n;
  assign timer_done = (cnt == '0);
  assign busy_done  = phim_en && (bcnt == BW'(BUSY_PHIM - 1));

  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      state <= ST_IDLE;
      wr_q  <= '0;
      bus_q <= BUS_RESET;
    end else begin
      state <= state_next;
      bus_q <= drive;
      if (pop) wr_q <= head;
    end
  end

  // Counters reload on any state change, so a state never inherits a stale count.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      cnt  <= '0;
      bcnt <= '0;
    end else if (state_next != state) begin
      cnt  <= cnt_load;
      bcnt <= '0;
    end else begin
      if (!timer_done) cnt <= cnt - CW'(1);
      if (state == ST_BUSY && phim_en) bcnt <= bcnt + BW'(1);
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: if (!empty) begin
        state_next = ST_A_SETUP;
        pop        = 1'b1;
      end
      ST_A_SETUP: if (timer_done) state_next = ST_A_PULSE;
      ST_A_PULSE: if (timer_done) state_next = ST_A_HOLD;
      ST_A_HOLD:  if (timer_done) state_next = ST_D_SETUP;
      ST_D_SETUP: if (timer_done) state_next = ST_D_PULSE;
      ST_D_PULSE: if (timer_done) state_next = ST_D_HOLD;
      ST_D_HOLD:  if (timer_done) state_next = ST_BUSY;
      ST_BUSY: if (busy_done) begin
        if (!empty) begin
          state_next = ST_A_SETUP;
          pop        = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    unique case (state_next)
      ST_A_SETUP, ST_D_SETUP: cnt_load = CW'(SETUP_CYC - 1);
      ST_A_PULSE, ST_D_PULSE: cnt_load = CW'(PULSE_CYC - 1);
      ST_A_HOLD,  ST_D_HOLD:  cnt_load = CW'(HOLD_CYC - 1);
      default:                cnt_load = '0;
    endcase
  end

  // Bus pins are registered from the current state, so they trail the FSM by one edge.
  always_comb begin
    drive      = bus_q;
    drive.cs_n = 1'b1;
    drive.wr_n = 1'b1;
    unique case (state)
      ST_A_SETUP, ST_A_PULSE, ST_A_HOLD: begin
        drive.cs_n = (state == ST_A_HOLD);
        drive.wr_n = (state != ST_A_PULSE);
        drive.a0   = 1'b0;
        drive.d    = wr_q[15:8];
      end
      ST_D_SETUP, ST_D_PULSE, ST_D_HOLD: begin
        drive.cs_n = (state == ST_D_HOLD);
        drive.wr_n = (state != ST_D_PULSE);
        drive.a0   = 1'b1;
        drive.d    = wr_q[7:0];
      end
      default: ;
    endcase
  end

  assign o_CS_n      = bus_q.cs_n;
  assign o_WR_n      = bus_q.wr_n;
  assign o_RD_n      = 1'b1;
  assign o_A0        = bus_q.a0;
  assign o_D         = bus_q.d;
  assign o_REQ_READY = !full;
  assign o_BUSY      = !empty || (state != ST_IDLE);

endmodule

// File: tb/tb_ika2151_write_sequencer.sv
// Bench for ika2151_write_sequencer: default-timing instance against a write-schedule
// model, plus a 1/1/1/1 instance against a literal waveform table.
module tb_ika2151_write_sequencer;
  localparam int S     = 15;
  localparam int P     = 20;
  localparam int H     = 15;
  localparam int BP    = 64;
  localparam int DEPTH = 4;
  localparam int T     = S + P + H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pcen_n = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] data = '0;
  logic       ready, cs_n, wr_n, rd_n, a0, busy;
  logic [7:0] d;
  logic [2:0] level;

  logic       f_valid = 1'b0;
  logic [7:0] f_addr = '0;
  logic [7:0] f_data = '0;
  logic       f_ready, f_cs_n, f_wr_n, f_rd_n, f_a0, f_busy;
  logic [7:0] f_d;
  logic [2:0] f_level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ika2151_write_sequencer dut (
    .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(pcen_n),
    .i_REQ_VALID(valid), .o_REQ_READY(ready), .i_REQ_ADDR(addr), .i_REQ_DATA(data),
    .o_CS_n(cs_n), .o_WR_n(wr_n), .o_RD_n(rd_n), .o_A0(a0), .o_D(d),
    .o_BUSY(busy), .o_LEVEL(level)
  );

  ika2151_write_sequencer #(
    .FIFO_DEPTH(4), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1), .BUSY_PHIM(1)
  ) dut_fast (
    .i_EMUCLK(clk), .i_RST(rst), .i_phiM_PCEN_n(1'b0),
    .i_REQ_VALID(f_valid), .o_REQ_READY(f_ready), .i_REQ_ADDR(f_addr), .i_REQ_DATA(f_data),
    .o_CS_n(f_cs_n), .o_WR_n(f_wr_n), .o_RD_n(f_rd_n), .o_A0(f_a0), .o_D(f_d),
    .o_BUSY(f_busy), .o_LEVEL(f_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // phiM enable source: mode 0 = every 4th cycle, mode 1 = never.
  int gcyc = 0;
  int en_mode = 0;
  always @(posedge clk) begin
    #1;
    gcyc++;
    pcen_n = (en_mode == 1) ? 1'b1 : ((gcyc % 4) != 0);
  end

  // Write-schedule model: each write starts its bus waveform at edge m_start and the
  // outputs follow from the offset k into a 2*T-cycle address+data window.
  logic [15:0] mq[$];
  logic [15:0] m_cur;
  bit          m_active = 0;
  bit          m_started = 0;
  int          m_start = 0;
  int          m_ecount = 0;
  int          ecyc = 0;
  int          m_pre, k, ph;
  bit          m_pop;
  logic        exp_cs = 1'b1, exp_wr = 1'b1, exp_a0 = 1'b0;
  logic [7:0]  exp_d = '0;

  always @(posedge clk) begin
    ecyc++;
    if (rst) begin
      mq.delete();
      m_active  = 0;
      m_started = 0;
      exp_cs = 1'b1; exp_wr = 1'b1; exp_a0 = 1'b0; exp_d = '0;
    end else begin
      m_pre = mq.size();
      m_pop = 0;
      if (!m_active) begin
        if (m_pre > 0) m_pop = 1;
      end else if (ecyc >= m_start + 2 * T && !pcen_n) begin
        m_ecount++;
        if (m_ecount == BP) begin
          if (m_pre > 0) m_pop = 1;
          else m_active = 0;
        end
      end
      if (m_pop) begin
        m_cur     = mq.pop_front();
        m_active  = 1;
        m_started = 1;
        m_start   = ecyc + 1;
        m_ecount  = 0;
      end
      if (valid && m_pre < DEPTH) mq.push_back({addr, data});
      exp_cs = 1'b1;
      exp_wr = 1'b1;
      if (m_started) begin
        k = ecyc - m_start;
        if (k >= 0 && k < 2 * T) begin
          ph     = (k < T) ? k : k - T;
          exp_a0 = (k >= T);
          exp_d  = (k >= T) ? m_cur[7:0] : m_cur[15:8];
          exp_cs = !(ph < S + P);
          exp_wr = !(ph >= S && ph < S + P);
        end
      end
    end
  end

  bit         cmp_en = 0;
  logic       wr_prev = 1'b1;
  logic [7:0] cap[$];
  int         max_level = 0;
  bit         ready_low = 0;
  int         cs_low_cnt = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cs_n", 32'(cs_n), 32'(exp_cs));
      chk("wr_n", 32'(wr_n), 32'(exp_wr));
      chk("rd_n", 32'(rd_n), 32'd1);
      chk("a0", 32'(a0), 32'(exp_a0));
      chk("d", 32'(d), 32'(exp_d));
      chk("busy", 32'(busy), 32'(m_active || mq.size() > 0));
      chk("level", 32'(level), 32'(mq.size()));
      chk("ready", 32'(ready), 32'(mq.size() < DEPTH));
      if (wr_n == 1'b0 && wr_prev == 1'b1) cap.push_back(d);
      wr_prev = wr_n;
      if (int'(level) > max_level) max_level = int'(level);
      if (!ready) ready_low = 1;
      if (!cs_n) cs_low_cnt++;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] dd);
    int n;
    n = 0;
    valid = 1'b1; addr = a; data = dd;
    while (!ready && n < 2000) begin
      tick();
      n++;
    end
    chk("push_wait_timeout", 32'(n < 2000), 32'd1);
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit, output int n);
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  logic [11:0] ftab [8];
  logic [7:0]  order [6];
  int n, c_a_cs, c_a_wr, c_d_cs, c_d_wr, c_ff;

  initial begin
    repeat (3) tick();
    cmp_en = 1;
    rst = 1'b0;
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_wr_n", 32'(wr_n), 32'd1);
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single write with defaults: latency and phase widths.
    push(8'h18, 8'hFF);
    chk("lat_edge_t", 32'(cs_n), 32'd1);
    tick();
    chk("lat_edge_t1", 32'(cs_n), 32'd1);
    tick();
    chk("lat_edge_t2", 32'(cs_n), 32'd0);
    chk("lat_d_addr", 32'(d), 32'h18);
    c_a_cs = 0; c_a_wr = 0; c_d_cs = 0; c_d_wr = 0; c_ff = 0;
    for (int i = 0; i < 120; i++) begin
      if (!cs_n && !a0) c_a_cs++;
      if (!wr_n && !a0) c_a_wr++;
      if (!cs_n && a0) c_d_cs++;
      if (!wr_n && a0) c_d_wr++;
      if (a0 && d == 8'hFF) c_ff++;
      tick();
    end
    chk("addr_cs_low_cycles", 32'(c_a_cs), 32'd35);
    chk("addr_wr_low_cycles", 32'(c_a_wr), 32'd20);
    chk("data_cs_low_cycles", 32'(c_d_cs), 32'd35);
    chk("data_wr_low_cycles", 32'(c_d_wr), 32'd20);
    chk("data_a0_hold_cycles", 32'(c_ff), 32'd70);
    wait_idle("busy_fall_timeout", 1000, n);
    chk("busy_window_len", 32'(n >= 232 && n <= 235), 32'd1);

    // Three back-to-back writes: order on the bus.
    cap.delete();
    push(8'h1B, 8'h02);
    push(8'h28, 8'h7F);
    push(8'h60, 8'h6F);
    wait_idle("seq3_timeout", 3000, n);
    order[0] = 8'h1B; order[1] = 8'h02; order[2] = 8'h28;
    order[3] = 8'h7F; order[4] = 8'h60; order[5] = 8'h6F;
    chk("seq3_count", 32'(cap.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < cap.size()) chk("seq3_byte", 32'(cap[i]), 32'(order[i]));

    // Six pushes: FIFO fills to 4 and the sixth waits for a pop.
    cap.delete();
    max_level = 0;
    ready_low = 0;
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i), 8'h80 + 8'(i));
    chk("fill_max_level", 32'(max_level), 32'd4);
    chk("fill_ready_dropped", 32'(ready_low), 32'd1);
    wait_idle("fill_timeout", 5000, n);
    chk("fill_strobes", 32'(cap.size()), 32'd12);

    // Reset during the address strobe drops everything.
    push(8'h20, 8'h55);
    push(8'h21, 8'h66);
    n = 0;
    while (wr_n && n < 200) begin
      tick();
      n++;
    end
    chk("apulse_wait_timeout", 32'(wr_n), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cs_n", 32'(cs_n), 32'd1);
    chk("midrst_wr_n", 32'(wr_n), 32'd1);
    chk("midrst_a0", 32'(a0), 32'd0);
    chk("midrst_d", 32'(d), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    cs_low_cnt = 0;
    repeat (300) tick();
    chk("midrst_no_activity", 32'(cs_low_cnt), 32'd0);

    // No phiM enables: stuck in the busy window, second write never starts.
    en_mode = 1;
    cap.delete();
    push(8'h30, 8'h11);
    push(8'h31, 8'h22);
    repeat (800) tick();
    chk("stall_strobes", 32'(cap.size()), 32'd2);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_level", 32'(level), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en_mode = 0;

    // 1/1/1 timing with BUSY_PHIM=1: {cs_n, wr_n, a0, d, busy} after edges t+1..t+8.
    ftab[0] = {3'b110, 8'h00, 1'b1};
    ftab[1] = {3'b010, 8'hA5, 1'b1};
    ftab[2] = {3'b000, 8'hA5, 1'b1};
    ftab[3] = {3'b110, 8'hA5, 1'b1};
    ftab[4] = {3'b011, 8'h3C, 1'b1};
    ftab[5] = {3'b001, 8'h3C, 1'b1};
    ftab[6] = {3'b111, 8'h3C, 1'b1};
    ftab[7] = {3'b111, 8'h3C, 1'b0};
    f_valid = 1'b1; f_addr = 8'hA5; f_data = 8'h3C;
    tick();
    f_valid = 1'b0;
    chk("fast_level_after_push", 32'(f_level), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("fast_wave", 32'({f_cs_n, f_wr_n, f_a0, f_d, f_busy}), 32'(ftab[i]));
    end
    chk("fast_rd_n", 32'(f_rd_n), 32'd1);
    chk("fast_ready", 32'(f_ready), 32'd1);

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
